// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that fronts a single-port synchronous RAM.
// Push and pop valid/ready streams share one RAM access per cycle, and reads have priority.
// A one-entry output register holds the FIFO head, which hides the RAM's one-cycle read latency.
module ram_fifo_ctrl #(
    parameter int D = 8,
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_valid,
    input  logic [D-1:0] i_wr_data,
    output logic         o_wr_ready,
    output logic         o_rd_valid,
    output logic [D-1:0] o_rd_data,
    input  logic         i_rd_ready,
    output logic [A:0]   o_count,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_ram_w_r,
    output logic [A-1:0] o_ram_addr,
    output logic [D-1:0] o_ram_wdata,
    input  logic [D-1:0] i_ram_rdata
);

    localparam int       DEPTH   = 1 << A;
    localparam logic [A:0] C_DEPTH = (A+1)'(DEPTH);

    logic [A-1:0] r_wptr;
    logic [A-1:0] r_rptr;
    logic [A:0]   r_mem_cnt;
    logic         r_inflight;
    logic         r_rd_valid;
    logic [D-1:0] r_rd_data;

    logic         w_pop;
    logic         w_do_read;
    logic         w_can_write;
    logic         w_push;
    logic [A-1:0] w_ram_addr;

    // Per-cycle arbitration: refill the output register first, otherwise offer the RAM to the writer
    always_comb begin
        w_pop       = r_rd_valid && i_rd_ready;
        w_do_read   = (r_mem_cnt != '0) && !r_inflight && (!r_rd_valid || w_pop);
        w_can_write = rst_n && !w_do_read && (r_mem_cnt != C_DEPTH);
        w_push      = w_can_write && i_wr_valid;
        w_ram_addr  = w_can_write ? r_wptr : r_rptr;
    end

    // Circular pointers and the count of entries still sitting in the RAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_do_read) begin
                r_rptr    <= r_rptr + A'(1);
                r_mem_cnt <= r_mem_cnt - (A+1)'(1);
            end else if (w_push) begin
                r_wptr    <= r_wptr + A'(1);
                r_mem_cnt <= r_mem_cnt + (A+1)'(1);
            end
        end
    end

    // Track the read issued last cycle so its data is captured exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_do_read;
        end
    end

    // Output register: capture returning RAM data, or clear it when the head is popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (r_inflight) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= i_ram_rdata;
        end else if (w_pop) begin
            r_rd_valid <= 1'b0;
        end
    end

    // Status and RAM-facing outputs
    always_comb begin
        o_wr_ready  = w_can_write;
        o_rd_valid  = r_rd_valid;
        o_rd_data   = r_rd_data;
        o_count     = r_mem_cnt + {{A{1'b0}}, r_inflight} + {{A{1'b0}}, r_rd_valid};
        o_full      = (r_mem_cnt == C_DEPTH);
        o_empty     = (o_count == '0);
        o_ram_w_r   = w_push;
        o_ram_addr  = w_ram_addr;
        o_ram_wdata = i_wr_data;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model.
module tb_ram_fifo_ctrl;

    localparam int D     = 8;
    localparam int A     = 3;
    localparam int DEPTH = 1 << A;
    localparam int CAP   = DEPTH + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wrValid = 1'b0;
    logic [D-1:0] wrData = '0;
    logic         wrReady;
    logic         rdValid;
    logic [D-1:0] rdData;
    logic         rdReady = 1'b0;
    logic [A:0]   count;
    logic         full;
    logic         empty;
    logic         ramWR;
    logic [A-1:0] ramAddr;
    logic [D-1:0] ramWdata;
    logic [D-1:0] ramRdata = '0;

    logic [D-1:0] ramMem [DEPTH];

    logic [D-1:0] modelQ [$];
    int           numChecks = 0;
    int           numFails = 0;
    int           popCount = 0;
    logic         prevStall = 1'b0;
    logic [D-1:0] prevData = '0;
    logic [D-1:0] lastPopped = '0;

    ram_fifo_ctrl #(.D(D), .A(A)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_valid  (wrValid),
        .i_wr_data   (wrData),
        .o_wr_ready  (wrReady),
        .o_rd_valid  (rdValid),
        .o_rd_data   (rdData),
        .i_rd_ready  (rdReady),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_ram_w_r   (ramWR),
        .o_ram_addr  (ramAddr),
        .o_ram_wdata (ramWdata),
        .i_ram_rdata (ramRdata)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Single-port synchronous RAM: write on w_r=1, otherwise registered read
    always @(posedge clk) begin
        if (ramWR) ramMem[ramAddr] <= ramWdata;
        else       ramRdata <= ramMem[ramAddr];
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive the push and pop inputs for the coming cycle
    task automatic applyStimulus(input logic wv, input logic [D-1:0] wd, input logic rr);
        wrValid = wv;
        wrData  = wd;
        rdReady = rr;
    endtask

    // Compare DUT against the queue model at the sample point, then apply this cycle's transfers
    task automatic modelCheck();
        logic wrFire;
        logic rdFire;
        wrFire = wrValid && wrReady;
        rdFire = rdValid && rdReady;
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
        checkOutput("ramWr", 32'(ramWR), 32'(wrFire));
        if (modelQ.size() == 0) checkOutput("rdValidWhenEmpty", 32'(rdValid), 0);
        if (modelQ.size() == CAP) begin
            checkOutput("wrReadyAtCap", 32'(wrReady), 0);
            checkOutput("fullAtCap", 32'(full), 1);
        end else if (modelQ.size() < DEPTH) begin
            checkOutput("fullBelowDepth", 32'(full), 0);
        end
        if (prevStall) begin
            checkOutput("holdValid", 32'(rdValid), 1);
            checkOutput("holdData", 32'(rdData), 32'(prevData));
        end
        if (wrFire) checkOutput("ramWdata", 32'(ramWdata), 32'(wrData));
        if (rdFire && modelQ.size() > 0) begin
            lastPopped = modelQ.pop_front();
            checkOutput("popData", 32'(rdData), 32'(lastPopped));
            popCount++;
        end
        if (wrFire) modelQ.push_back(wrData);
        prevStall = rdValid && !rdReady;
        prevData  = rdData;
    endtask

    // One full clock cycle with model checking
    task automatic runCycle(input logic wv, input logic [D-1:0] wd, input logic rr);
        applyStimulus(wv, wd, rr);
        @(negedge clk);
        modelCheck();
        @(posedge clk);
        #1;
    endtask

    // Hold a push until accepted, with a bounded wait
    task automatic pushValue(input logic [D-1:0] val, input logic rr);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++) begin
            applyStimulus(1'b1, val, rr);
            @(negedge clk);
            acc = wrReady;
            modelCheck();
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, '0, rr);
        checkOutput("pushAccepted", 32'(acc), 1);
    endtask

    // Pop until the model is empty, with a bounded wait
    task automatic drain(input int maxCycles);
        for (int i = 0; i < maxCycles && modelQ.size() != 0; i++) runCycle(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("drainEmpty", 32'(empty), 1);
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check the immediate effect, then release it
    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstCount", 32'(count), 0);
        checkOutput("rstEmpty", 32'(empty), 1);
        checkOutput("rstRdValid", 32'(rdValid), 0);
        checkOutput("rstRamWr", 32'(ramWR), 0);
        checkOutput("rstRamAddr", 32'(ramAddr), 0);
        modelQ.delete();
        prevStall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int startPops;

        // Power-on reset
        #2;
        checkOutput("porCount", 32'(count), 0);
        checkOutput("porEmpty", 32'(empty), 1);
        checkOutput("porFull", 32'(full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        doReset();

        // Single push: write, read issue, then capture two edges after accept
        $display("[TB] single push");
        applyStimulus(1'b1, 8'h64, 1'b0);
        @(negedge clk);
        checkOutput("spWr", 32'(ramWR), 1);
        checkOutput("spAddr", 32'(ramAddr), 0);
        checkOutput("spReady", 32'(wrReady), 1);
        modelCheck();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("spReadIssueWr", 32'(ramWR), 0);
        checkOutput("spReadAddr", 32'(ramAddr), 0);
        checkOutput("spWrStall", 32'(wrReady), 0);
        checkOutput("spNotValidE0", 32'(rdValid), 0);
        modelCheck();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("spNotValidE1", 32'(rdValid), 0);
        modelCheck();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("spValidE2", 32'(rdValid), 1);
        checkOutput("spData", 32'(rdData), 32'h64);
        checkOutput("spCount", 32'(count), 1);
        modelCheck();
        @(posedge clk);
        #1;
        drain(20);

        // Fill to total capacity, confirm stall, then drain in order
        $display("[TB] fill");
        for (int v = 100; v <= 108; v++) pushValue(D'(v), 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd109, 1'b0);
            @(negedge clk);
            checkOutput("fillFull", 32'(full), 1);
            checkOutput("fillReady", 32'(wrReady), 0);
            checkOutput("fillCount", 32'(count), 9);
            modelCheck();
            @(posedge clk);
            #1;
        end
        startPops = popCount;
        drain(40);
        checkOutput("fillPopCount", 32'(popCount - startPops), 9);
        checkOutput("fillLast", 32'(lastPopped), 108);

        // Streaming push/pop across pointer wrap
        $display("[TB] wrap");
        startPops = popCount;
        for (int v = 130; v <= 149; v++) pushValue(D'(v), 1'b1);
        drain(40);
        checkOutput("wrapPopCount", 32'(popCount - startPops), 20);
        checkOutput("wrapLast", 32'(lastPopped), 149);

        // Back-pressure: head must hold while rd_ready is low
        $display("[TB] back-pressure");
        pushValue(8'h11, 1'b0);
        pushValue(8'h22, 1'b0);
        pushValue(8'h33, 1'b0);
        for (int i = 0; i < 10 && !rdValid; i++) runCycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            @(negedge clk);
            checkOutput("bpValid", 32'(rdValid), 1);
            checkOutput("bpData", 32'(rdData), 32'h11);
            checkOutput("bpCount", 32'(count), 3);
            modelCheck();
            @(posedge clk);
            #1;
        end
        drain(20);
        checkOutput("bpLast", 32'(lastPopped), 32'h33);

        // Reset with a read in flight and four entries held
        $display("[TB] mid-op reset");
        for (int v = 8'h41; v <= 8'h45; v++) pushValue(D'(v), 1'b0);
        for (int i = 0; i < 4; i++) runCycle(1'b0, '0, 1'b0);
        runCycle(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("preResetCount", 32'(count), 4);
        checkOutput("preResetNotValid", 32'(rdValid), 0);
        doReset();
        for (int i = 0; i < 3; i++) runCycle(1'b0, '0, 1'b0);
        startPops = popCount;
        pushValue(8'h96, 1'b1);
        drain(20);
        checkOutput("postResetPops", 32'(popCount - startPops), 1);
        checkOutput("postResetFirst", 32'(lastPopped), 32'h96);

        // Randomised traffic with varying pop pressure
        $display("[TB] random traffic");
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                runCycle(1'($urandom_range(0, 1)), D'($urandom),
                         1'($urandom_range(0, 3) < phase));
            end
        end
        drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
